// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the byte-memory DMA engine.
package mem_pkg;
  localparam int MEM_AW = 12;
  localparam int MEM_DW = 8;
  localparam int MEM_LW = 13;

  // Block-select field inside a memory address.
  localparam int BLK_HI = 11;
  localparam int BLK_LO = 10;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {IDLE, RD, WR, FW, FIN} state_e;
endpackage

// File: rtl/mem_dma_addr_gen.sv
// Latched source/destination bases plus the byte index; produces the
// per-byte addresses (modulo 2^AW) and the last-byte flag.
module mem_dma_addr_gen
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] src_nxt,
  output logic [AW-1:0] dst_addr,
  output logic [AW-1:0] dst_nxt,
  output logic          last
);
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, i_q, i_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      i_q   <= '0;
    end else if (load) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
      i_q   <= '0;
    end else if (inc) begin
      i_q   <= i_nxt;
    end
  end

  assign i_nxt    = i_q + 1'b1;
  assign dst_addr = dst_q + i_q[AW-1:0];
  assign src_nxt  = src_q + i_nxt[AW-1:0];
  assign dst_nxt  = dst_q + i_nxt[AW-1:0];
  // i+1 fits in LW bits even for a full 4096-byte transfer.
  assign last     = (i_nxt == len_q);
endmodule

// File: rtl/mem_dma.sv
// Block copy / fill engine driving a byte memory with registered read data.
// Copy alternates RD/WR (2 cycles per byte); fill writes every cycle.
module mem_dma
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] pattern,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_e        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          mode_q;
  logic [DW-1:0] pattern_q;
  logic          load, inc, last;
  logic [AW-1:0] src_nxt, dst_addr, dst_nxt;

  mem_dma_addr_gen #(.AW(AW), .LW(LW)) u_agen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .inc     (inc),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .src_nxt (src_nxt),
    .dst_addr(dst_addr),
    .dst_nxt (dst_nxt),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      mode_q    <= MODE_COPY;
      pattern_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      if (load) begin
        mode_q    <= mode;
        pattern_q <= pattern;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load = 1'b1;
        if (len == '0) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (mode == MODE_FILL) begin
          state_d = FW;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          addr_d  = dst;
        end else begin
          state_d = RD;
          busy_d  = 1'b1;
          addr_d  = src;
        end
      end
      RD: begin
        state_d = WR;
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = dst_addr;
      end
      WR: begin
        inc = 1'b1;
        if (last) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
          busy_d  = 1'b1;
          addr_d  = src_nxt;
        end
      end
      FW: begin
        inc = 1'b1;
        if (last) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          we_d   = 1'b1;
          addr_d = dst_nxt;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  // In copy mode the write data is the byte read on the preceding RD cycle.
  assign mem_wdata = (mode_q == MODE_FILL) ? pattern_q : mem_rdata;
endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma with a behavioural registered-read byte memory.
module tb_mem_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] src = '0, dst = '0;
  logic [12:0] len = '0;
  logic [7:0]  pattern = '0;
  logic        busy, done, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  mem [4096];
  logic [7:0]  sh  [4096];

  typedef struct {logic [11:0] addr; logic [7:0] data;} wr_t;
  wr_t sb_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, c0 = 0, done_cyc = 0;
  int we_cnt = 0, busy_cnt = 0, done_cnt = 0;
  bit done_seen = 0;

  mem_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src),
    .dst(dst), .len(len), .pattern(pattern), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        if (sb_q.size() == 0) chk("we_unexpected", 1, 0);
        else begin
          wr_t e;
          e = sb_q.pop_front();
          chk("wr_addr", {20'h0, mem_addr}, {20'h0, e.addr});
          chk("wr_data", {24'h0, mem_wdata}, {24'h0, e.data});
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (!done_seen) done_cyc = cyc;
        done_seen = 1;
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    sh[a] = d;
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic launch(input logic m, input logic [11:0] s, input logic [11:0] d,
                        input int n, input logic [7:0] p);
    for (int i = 0; i < n; i++) begin
      logic [11:0] wa;
      logic [11:0] ra;
      wr_t e;
      wa = d + 12'(i);
      ra = s + 12'(i);
      e.addr = wa;
      e.data = m ? p : sh[ra];
      sh[wa] = e.data;
      sb_q.push_back(e);
    end
    we_cnt = 0; busy_cnt = 0; done_cnt = 0; done_seen = 0;
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = 13'(n); pattern = p;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_xfer(input int bound);
    for (int k = 0; k < bound && !done_seen; k++) begin
      @(negedge clk);
      #1;
    end
    chk("done_timeout", {31'h0, done_seen}, 1);
    repeat (4) @(negedge clk);
    #1 chk("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #1 chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_we", {31'h0, mem_we}, 0);
    chk("rst_addr", {20'h0, mem_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    preload(12'h010, 8'hA1); preload(12'h011, 8'hB2);
    preload(12'h012, 8'hC3); preload(12'h013, 8'hD4);
    preload(12'h002, 8'h33);
    preload(12'h100, 8'h77); preload(12'h101, 8'h00); preload(12'h102, 8'h00);
    preload(12'h300, 8'h11);
    for (int i = 0; i < 8; i++) begin
      preload(12'h400 + 12'(i), 8'h10 + 8'(i));
      preload(12'h500 + 12'(i), 8'hEE);
    end

    // Copy 4 bytes
    launch(1'b0, 12'h010, 12'h800, 4, 8'h00);
    finish_xfer(30);
    chk("copy_lat", done_cyc - c0 + 1, 9);
    chk("copy_we", we_cnt, 4);
    chk("copy_busy", busy_cnt, 8);
    chk("copy_done", done_cnt, 1);
    chk("copy_m0", {24'h0, mem[12'h800]}, 32'hA1);
    chk("copy_m1", {24'h0, mem[12'h801]}, 32'hB2);
    chk("copy_m2", {24'h0, mem[12'h802]}, 32'hC3);
    chk("copy_m3", {24'h0, mem[12'h803]}, 32'hD4);

    // Fill across the top of the address space
    launch(1'b1, 12'h000, 12'hFFE, 4, 8'h5A);
    finish_xfer(30);
    chk("fill_lat", done_cyc - c0 + 1, 5);
    chk("fill_we", we_cnt, 4);
    chk("fill_ffe", {24'h0, mem[12'hFFE]}, 32'h5A);
    chk("fill_fff", {24'h0, mem[12'hFFF]}, 32'h5A);
    chk("fill_000", {24'h0, mem[12'h000]}, 32'h5A);
    chk("fill_001", {24'h0, mem[12'h001]}, 32'h5A);
    chk("fill_002", {24'h0, mem[12'h002]}, 32'h33);

    // Zero length
    launch(1'b0, 12'h010, 12'h900, 0, 8'h00);
    finish_xfer(10);
    chk("len0_lat", done_cyc - c0 + 1, 1);
    chk("len0_we", we_cnt, 0);
    chk("len0_busy", busy_cnt, 0);
    chk("len0_done", done_cnt, 1);

    // Overlapping forward copy
    launch(1'b0, 12'h100, 12'h101, 2, 8'h00);
    finish_xfer(20);
    chk("ovl_101", {24'h0, mem[12'h101]}, 32'h77);
    chk("ovl_102", {24'h0, mem[12'h102]}, 32'h77);

    // start while busy is ignored
    launch(1'b1, 12'h000, 12'h200, 6, 8'hC7);
    @(negedge clk);
    start = 1'b1; dst = 12'h300; pattern = 8'h99;
    @(negedge clk);
    start = 1'b0;
    finish_xfer(30);
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_we", we_cnt, 6);
    chk("busy_start_300", {24'h0, mem[12'h300]}, 32'h11);
    chk("busy_start_205", {24'h0, mem[12'h205]}, 32'hC7);

    // Asynchronous reset in the middle of a copy
    launch(1'b0, 12'h400, 12'h500, 8, 8'h00);
    for (int k = 0; k < 40 && we_cnt < 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_mid_reach", {31'h0, we_cnt >= 2}, 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_we", {31'h0, mem_we}, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    chk("rst_mid_done", {31'h0, done}, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_500", {24'h0, mem[12'h500]}, 32'h10);
    chk("rst_mid_501", {24'h0, mem[12'h501]}, 32'h11);
    for (int i = 2; i < 8; i++) begin
      chk("rst_mid_untouched", {24'h0, mem[12'h500 + 12'(i)]}, 32'hEE);
      sh[12'h500 + 12'(i)] = 8'hEE;
    end
    sb_q.delete();
    rst_n = 1'b1;

    launch(1'b1, 12'h000, 12'h600, 3, 8'h3C);
    finish_xfer(20);
    chk("post_rst_lat", done_cyc - c0 + 1, 4);
    chk("post_rst_602", {24'h0, mem[12'h602]}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Initiator-side engine for the 4-block byte memory: drives its `we`/`addr`/`in` port and consumes its registered `out`.
- Performs block copy (src→dst) or block fill (constant byte→dst) over the 12-bit address space, so software/CPU logic need not sequence byte moves.
- Sits between the control path and the memory; while busy it owns the memory port exclusively.

Parameters:
- AW, 12, memory address width (2-bit block select + 10-bit pointer).
- DW, 8, memory data width.
- LW, 13, length width; covers 0..4096 bytes.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; latched at start
- src  in  AW  copy source base; latched at start
- dst  in  AW  destination base; latched at start
- len  in  LW  byte count; latched at start
- pattern  in  DW  fill byte; latched at start
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- mem_we  out  1  to memory write enable
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory registered read data, valid one cycle after address

Behaviour:
- Reset:
  - Asynchronous, active-low; takes effect immediately, including mid-transfer.
  - Values: state IDLE, busy=0, done=0, mem_we=0, mem_addr=0.
  - Partially completed transfers are abandoned; no further writes occur.
- Registered outputs: busy, done, mem_we and mem_addr come from flops.
- mem_wdata: combinational mux, mem_rdata in copy mode, latched pattern in fill mode.
- FSM states:
  - IDLE: on start=1 latch inputs, clear index i; busy<=1.
    - len=0: go to FIN, no memory access.
    - copy: go to RD with mem_addr<=src, mem_we<=0.
    - fill: go to FW with mem_addr<=dst, mem_we<=1.
  - RD (copy): memory samples mem_addr=src+i. Next state WR with mem_addr<=dst+i, mem_we<=1.
  - WR (copy): mem_rdata holds mem[src+i] and is written to dst+i at this edge; i<=i+1.
    - i+1==len: go to FIN, mem_we<=0.
    - otherwise: go to RD, mem_addr<=src+i+1, mem_we<=0.
  - FW (fill): pattern is written to dst+i; i<=i+1. Stay until i+1==len, then FIN with mem_we<=0.
  - FIN: done=1 for exactly this cycle, busy=0; return to IDLE.
- Latency and throughput:
  - Copy: 2 cycles per byte. First write edge is 2 cycles after the start-sampling edge. done asserts 2·len+1 cycles after the start edge.
  - Fill: 1 cycle per byte. done asserts len+1 cycles after the start edge.
- Address arithmetic:
  - Modulo 2^AW; wraps 0xFFF→0x000 across blocks with no error.
  - i is LW bits wide; len=4096 covers the full space.
- Overlap: strictly forward, byte-at-a-time. With dst=src+1 the first byte propagates; memmove semantics are not provided.
- start while busy or in FIN: ignored, not queued. start in IDLE on the same cycle FIN exits is accepted.
- Input changes after the start edge have no effect on the running transfer.
- mem_we is never 1 in IDLE, RD or FIN.

Decomposition:
- Shared package mem_pkg holds:
  - AW/DW constants and the block-select field position [11:10].
  - The FSM state enum (IDLE, RD, WR, FW, FIN).
  - MODE_COPY/MODE_FILL constants.
- Natural sub-module: mem_dma_addr_gen, holding the latched bases and the index counter and producing src+i, dst+i and the last-byte flag. The FSM stays in mem_dma.
- The bench instantiates the existing memory model as the responder.

Test Plan:
- Copy: preload 0x010..0x013 = A1,B2,C3,D4; start copy src=0x010, dst=0x800, len=4.
  - Memory: 0x800..0x803 = A1,B2,C3,D4.
  - Timing: exactly 4 mem_we pulses, done pulse 9 cycles after start, busy high for 8 cycles.
- Fill wrap: dst=0xFFE, len=4, pattern=5A.
  - Memory: 0xFFE, 0xFFF, 0x000, 0x001 = 5A; 0x002 untouched; done 5 cycles after start.
- len=0: start copy with len=0.
  - No mem_we ever, done 1 cycle after start, busy never high.
- Overlap: mem[0x100]=77, mem[0x101]=00, mem[0x102]=00; copy src=0x100, dst=0x101, len=2.
  - Memory: 0x101=77, 0x102=77.
- start while busy: second start pulse mid-fill with different dst.
  - Ignored; only the first region is written; exactly one done pulse.
- Reset mid-copy: assert rst_n=0 after the second write of a len=8 copy.
  - mem_we=0, busy=0, done=0 immediately (asynchronous).
  - Only 2 destination bytes changed; after release, a new start works normally.
